// File: rtl/full_adder_unit_pkg.sv
// Shared constants and the 1-bit full-adder equation used by the cell.
// Compile before every other file of this block.
package full_adder_pkg;

  localparam int FA_DEFAULT_WIDTH = 1;

  // Returns {co, s} for one full-adder bit.
  function automatic logic [1:0] fa_bit(input logic a, input logic b, input logic c);
    logic s;
    logic co;
    s  = a ^ b ^ c;
    co = (a & b) | (a & c) | (b & c);
    return {co, s};
  endfunction

endpackage

// File: rtl/full_adder_unit_if.sv
// Operand/result bundle between the adder and its user.
// FULL_ADDER_UNIT_OVF_EN adds the registered signed-overflow flag ovf.
interface full_adder_unit_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             in_valid;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             out_valid;
`ifdef FULL_ADDER_UNIT_OVF_EN
  logic             ovf;

  modport master (
    output a, b, cin, in_valid,
    input  sum, cout, out_valid, ovf
  );

  modport slave (
    input  a, b, cin, in_valid,
    output sum, cout, out_valid, ovf
  );
`else
  modport master (
    output a, b, cin, in_valid,
    input  sum, cout, out_valid
  );

  modport slave (
    input  a, b, cin, in_valid,
    output sum, cout, out_valid
  );
`endif

endinterface

// File: rtl/full_adder_unit_cell.sv
// Combinational 1-bit full-adder cell; chained by full_adder_unit to form
// a ripple-carry adder.
module full_adder_cell
  import full_adder_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign {co, s} = fa_bit(a, b, ci);

endmodule

// File: rtl/full_adder_unit.sv
// Registered ripple-carry adder: {cout,sum} = a + b + cin, one cycle of latency.
// Define FULL_ADDER_UNIT_OVF_EN to also register the signed-overflow flag ovf.
module full_adder_unit
  import full_adder_pkg::*;
#(
  parameter int WIDTH = FA_DEFAULT_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  full_adder_unit_if.slave  bus
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_d;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             out_valid_q;

  assign carry[0] = bus.cin;

  // carry[gi] enters bit gi; carry[WIDTH] leaves the MSB as cout
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
      full_adder_cell u_cell (
        .a  (bus.a[gi]),
        .b  (bus.b[gi]),
        .ci (carry[gi]),
        .s  (sum_d[gi]),
        .co (carry[gi+1])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q       <= '0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        sum_q  <= sum_d;
        cout_q <= carry[WIDTH];
      end
    end
  end

  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.out_valid = out_valid_q;

`ifdef FULL_ADDER_UNIT_OVF_EN
  logic ovf_d;
  logic ovf_q;

  // Signed overflow: the carry into the sign bit disagrees with the carry out of it
  assign ovf_d = carry[WIDTH] ^ carry[WIDTH-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (bus.in_valid) begin
      ovf_q <= ovf_d;
    end
  end

  assign bus.ovf = ovf_q;
`endif

endmodule

// File: tb/tb_full_adder_unit.sv
// Self-checking bench for full_adder_unit at WIDTH=1 and WIDTH=8 against an
// arithmetic reference model of the registered adder.
module tb_full_adder_unit;

  logic clk = 1'b0;
  logic rst1;
  logic rst8;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  full_adder_unit_if #(.WIDTH(1)) bus1 ();
  full_adder_unit_if #(.WIDTH(8)) bus8 ();

  full_adder_unit #(.WIDTH(1)) dut1 (
    .clk (clk),
    .rst (rst1),
    .bus (bus1)
  );

  full_adder_unit #(.WIDTH(8)) dut8 (
    .clk (clk),
    .rst (rst8),
    .bus (bus8)
  );

  // Expected registered state of each instance
  logic [7:0] exp8_sum;
  logic       exp8_cout;
  logic       exp8_valid;
  logic       exp8_ovf;
  logic       exp1_sum;
  logic       exp1_cout;
  logic       exp1_valid;
  logic       exp1_ovf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Signed overflow of a w-bit two's-complement a + b + cin, by integer range
  function automatic logic signed_ovf(input int w, input int ua, input int ub, input int c);
    int sa;
    int sb;
    int t;
    sa = (ua >= (1 << (w - 1))) ? ua - (1 << w) : ua;
    sb = (ub >= (1 << (w - 1))) ? ub - (1 << w) : ub;
    t  = sa + sb + c;
    return (t > (1 << (w - 1)) - 1) || (t < -(1 << (w - 1)));
  endfunction

  task automatic step8(input string tag, input logic r, input logic v,
                       input logic [7:0] a, input logic [7:0] b, input logic c);
    int total;
    rst8          = r;
    bus8.in_valid = v;
    bus8.a        = a;
    bus8.b        = b;
    bus8.cin      = c;
    @(posedge clk);
    total = int'(a) + int'(b) + int'(c);
    if (r) begin
      exp8_sum = '0; exp8_cout = 1'b0; exp8_valid = 1'b0; exp8_ovf = 1'b0;
    end else begin
      exp8_valid = v;
      if (v) begin
        exp8_sum  = total[7:0];
        exp8_cout = (total >= 256);
        exp8_ovf  = signed_ovf(8, int'(a), int'(b), int'(c));
      end
    end
    #1;
    $display("w8 %s rst=%0b v=%0b a=%02h b=%02h cin=%0b -> sum=%02h cout=%0b ov=%0b",
             tag, r, v, a, b, c, bus8.sum, bus8.cout, bus8.out_valid);
    check({tag, ".sum"}, 32'(bus8.sum), 32'(exp8_sum));
    check({tag, ".cout"}, 32'(bus8.cout), 32'(exp8_cout));
    check({tag, ".out_valid"}, 32'(bus8.out_valid), 32'(exp8_valid));
`ifdef FULL_ADDER_UNIT_OVF_EN
    check({tag, ".ovf"}, 32'(bus8.ovf), 32'(exp8_ovf));
`endif
  endtask

  task automatic step1(input string tag, input logic r, input logic v,
                       input logic a, input logic b, input logic c);
    int total;
    rst1          = r;
    bus1.in_valid = v;
    bus1.a        = a;
    bus1.b        = b;
    bus1.cin      = c;
    @(posedge clk);
    total = int'(a) + int'(b) + int'(c);
    if (r) begin
      exp1_sum = 1'b0; exp1_cout = 1'b0; exp1_valid = 1'b0; exp1_ovf = 1'b0;
    end else begin
      exp1_valid = v;
      if (v) begin
        exp1_sum  = (total % 2) == 1;
        exp1_cout = (total >= 2);
        exp1_ovf  = signed_ovf(1, int'(a), int'(b), int'(c));
      end
    end
    #1;
    $display("w1 %s rst=%0b v=%0b a=%0b b=%0b cin=%0b -> sum=%0b cout=%0b ov=%0b",
             tag, r, v, a, b, c, bus1.sum, bus1.cout, bus1.out_valid);
    check({tag, ".sum"}, 32'(bus1.sum), 32'(exp1_sum));
    check({tag, ".cout"}, 32'(bus1.cout), 32'(exp1_cout));
    check({tag, ".out_valid"}, 32'(bus1.out_valid), 32'(exp1_valid));
`ifdef FULL_ADDER_UNIT_OVF_EN
    check({tag, ".ovf"}, 32'(bus1.ovf), 32'(exp1_ovf));
`endif
  endtask

  initial begin
    rst1 = 1'b1; rst8 = 1'b1;
    bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0; bus1.in_valid = 1'b0;
    bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0; bus8.in_valid = 1'b0;

    // WIDTH=1: reset has priority over valid operands
    step1("w1_rst0", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    step1("w1_rst1", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      logic [2:0] abc;
      abc = 3'(i);
      step1($sformatf("w1_exh%0d", i), 1'b0, 1'b1, abc[2], abc[1], abc[0]);
    end
    step1("w1_hold_load", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step1($sformatf("w1_hold%0d", i), 1'b0, 1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
    end
    step1("w1_mid_load", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    step1("w1_mid_rst", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    step1("w1_post", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);

    // WIDTH=8
    step8("w8_rst0", 1'b1, 1'b1, 8'h01, 8'h01, 1'b1);
    step8("w8_rst1", 1'b1, 1'b1, 8'h01, 8'h01, 1'b1);
    step8("w8_max", 1'b0, 1'b1, 8'hFF, 8'hFF, 1'b1);
    step8("w8_8080", 1'b0, 1'b1, 8'h80, 8'h80, 1'b0);
    step8("w8_zero", 1'b0, 1'b1, 8'h00, 8'h00, 1'b0);
    step8("w8_7f01", 1'b0, 1'b1, 8'h7F, 8'h01, 1'b0);
    step8("w8_hold_load", 1'b0, 1'b1, 8'h5A, 8'h21, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step8($sformatf("w8_hold%0d", i), 1'b0, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
    end
    for (int i = 0; i < 24; i++) begin
      logic v;
      v = (i < 10) ? 1'b1 : ($urandom_range(0, 3) != 0);
      step8($sformatf("w8_rnd%0d", i), 1'b0, v, 8'($urandom), 8'($urandom), 1'($urandom));
    end
    step8("w8_mid_load", 1'b0, 1'b1, 8'hC3, 8'h99, 1'b1);
    step8("w8_mid_rst", 1'b1, 1'b1, 8'hFF, 8'h01, 1'b0);
    step8("w8_post", 1'b0, 1'b1, 8'h12, 8'h34, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
